// File: rtl/bcd_pkg.sv
// Shared definitions for the 6-bit binary to two-digit BCD converter.
// Holds the datapath widths, the number of double-dabble steps per
// conversion, and the state type of the sequential converter FSM.
package bcd_pkg;

  localparam int IN_W    = 6;   // binary input width (0..63)
  localparam int DIGIT_W = 4;   // one BCD digit
  localparam int STEPS   = 6;   // one shift-add-3 step per input bit
  localparam int CNT_W   = 3;   // wide enough to count 0..STEPS-1

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit-correction cell: adds 3 to a BCD digit that is 5 or
// more, so that the following left shift carries correctly into the next
// decimal digit.
//   i_digit : digit before correction
//   o_digit : corrected digit
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= DIGIT_W'(5)) begin
      o_digit = i_digit + DIGIT_W'(3);
    end
  end

endmodule : bcd_add3

// File: rtl/bcd.sv
// 6-bit binary to two-digit BCD converter with two independent paths:
//   - a purely combinational path (o_ones/o_tens follow i_in at all times)
//   - a registered double-dabble path that converts a captured value in
//     six clock edges and reports it on o_ones_q/o_tens_q.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_in     : unsigned binary value 0..63
//   o_ones   : combinational ones digit of i_in
//   o_tens   : combinational tens digit of i_in
//   i_start  : request a registered conversion of i_in (ignored while busy)
//   o_busy   : registered conversion in progress
//   o_done   : one-cycle pulse when o_ones_q/o_tens_q have been updated
//   o_ones_q : ones digit of the last completed conversion
//   o_tens_q : tens digit of the last completed conversion
module bcd
  import bcd_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [IN_W-1:0]    i_in,
  output logic [DIGIT_W-1:0] o_ones,
  output logic [DIGIT_W-1:0] o_tens,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic [DIGIT_W-1:0] o_ones_q,
  output logic [DIGIT_W-1:0] o_tens_q
);

  // Combinational path: constant divide/modulo, independent of clock and reset.
  assign o_ones = DIGIT_W'(i_in % IN_W'(10));
  assign o_tens = DIGIT_W'(i_in / IN_W'(10));

  state_t             state_q, state_d;
  logic [IN_W-1:0]    shift_q, shift_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DIGIT_W-1:0] res_ones_q, res_ones_d;
  logic [DIGIT_W-1:0] res_tens_q, res_tens_d;

  logic [DIGIT_W-1:0] ones_adj, tens_adj;
  logic [DIGIT_W-1:0] ones_step, tens_step;
  logic [IN_W-1:0]    shift_step;

  bcd_add3 u_add3_ones (.i_digit(ones_q), .o_digit(ones_adj));
  bcd_add3 u_add3_tens (.i_digit(tens_q), .o_digit(tens_adj));

  // One double-dabble step: correct both digits, then shift the whole
  // {tens, ones, shift} chain left by one bit. The corrected tens digit
  // never exceeds 3 for a 6-bit input, so nothing is lost off the top.
  assign tens_step  = {tens_adj[DIGIT_W-2:0], ones_adj[DIGIT_W-1]};
  assign ones_step  = {ones_adj[DIGIT_W-2:0], shift_q[IN_W-1]};
  assign shift_step = {shift_q[IN_W-2:0], 1'b0};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_ones_d = res_ones_q;
    res_tens_d = res_tens_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = CONVERT;
          shift_d = i_in;
          ones_d  = '0;
          tens_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CONVERT: begin
        shift_d = shift_step;
        ones_d  = ones_step;
        tens_d  = tens_step;
        cnt_d   = cnt_q + CNT_W'(1);
        // The last step publishes its own freshly shifted digits directly.
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          res_ones_d = ones_step;
          res_tens_d = tens_step;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      ones_q     <= '0;
      tens_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_ones_q <= '0;
      res_tens_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_ones_q <= res_ones_d;
      res_tens_q <= res_tens_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_ones_q = res_ones_q;
  assign o_tens_q = res_tens_q;

endmodule : bcd

// File: tb/tb_bcd.sv
// Self-checking bench for bcd: exhaustive combinational sweep, directed
// registered-path scenarios, then randomized start/input/reset traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_bcd;

  logic       i_clk;
  logic       i_rst;
  logic [5:0] i_in;
  logic [3:0] o_ones;
  logic [3:0] o_tens;
  logic       i_start;
  logic       o_busy;
  logic       o_done;
  logic [3:0] o_ones_q;
  logic [3:0] o_tens_q;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining edges of the running conversion, the
  // captured value, and the last published result.
  int m_remaining;
  int m_val;
  int m_done;
  int m_ones;
  int m_tens;

  bcd dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_in     (i_in),
    .o_ones   (o_ones),
    .o_tens   (o_tens),
    .i_start  (i_start),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_ones_q (o_ones_q),
    .o_tens_q (o_tens_q)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_remaining = 0;
    m_val       = 0;
    m_done      = 0;
    m_ones      = 0;
    m_tens      = 0;
  endtask

  // Model behaviour at one rising edge, given the inputs present at it.
  task automatic model_edge(input bit rst, input bit start, input int in_val);
    if (rst) begin
      model_reset();
    end else begin
      m_done = 0;
      if (m_remaining > 0) begin
        m_remaining--;
        if (m_remaining == 0) begin
          m_ones = m_val % 10;
          m_tens = m_val / 10;
          m_done = 1;
        end
      end else if (start) begin
        m_val       = in_val;
        m_remaining = 6;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"},   o_busy,   (m_remaining > 0) ? 1 : 0);
    check({tag, ".done"},   o_done,   m_done);
    check({tag, ".ones_q"}, o_ones_q, m_ones);
    check({tag, ".tens_q"}, o_tens_q, m_tens);
    check({tag, ".excl"},   o_busy & o_done, 0);
    check({tag, ".ones"},   o_ones,   int'(i_in) % 10);
    check({tag, ".tens"},   o_tens,   int'(i_in) / 10);
  endtask

  // Advance one edge, update the model, then sample 1 ns later.
  task automatic cycle(input string tag);
    @(posedge i_clk);
    model_edge(i_rst, i_start, int'(i_in));
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    i_rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    check({tag, ".busy0"}, o_busy, 0);
    check({tag, ".ones_q0"}, o_ones_q, 0);
    cycle({tag, ".hold"});
    i_rst = 1'b0;
  endtask

  initial begin
    int dones;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_in    = '0;
    model_reset();
    #1;
    check_all("reset");

    // Combinational outputs must work while reset is held.
    for (int i = 0; i < 64; i += 7) begin
      i_in = 6'(i);
      #1;
      check("rst_comb.ones", o_ones, i % 10);
      check("rst_comb.tens", o_tens, i / 10);
    end

    // Exhaustive combinational sweep.
    for (int i = 0; i < 64; i++) begin
      i_in = 6'(i);
      #1;
      check("sweep.ones", o_ones, i % 10);
      check("sweep.tens", o_tens, i / 10);
      check("sweep.tens_b3", o_tens[3], 0);
    end

    cycle("rst_edge");
    i_rst = 1'b0;

    // First start after reset is honoured at the very next edge; 47 -> 7/4.
    i_in    = 6'd47;
    i_start = 1'b1;
    cycle("s47.cap");
    check("s47.busy_cap", o_busy, 1);
    i_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cycle("s47.run");
      check("s47.busy_run", o_busy, 1);
      check("s47.done_run", o_done, 0);
    end
    cycle("s47.fin");
    check("s47.done", o_done, 1);
    check("s47.ones_q", o_ones_q, 7);
    check("s47.tens_q", o_tens_q, 4);
    cycle("s47.post");
    check("s47.done_off", o_done, 0);
    check("s47.hold_ones", o_ones_q, 7);

    // Start while busy is ignored; input change after capture is ignored.
    i_in    = 6'd47;
    i_start = 1'b1;
    cycle("ign.cap");
    i_start = 1'b0;
    i_in    = 6'd59;
    dones   = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        i_start = 1'b1;
        i_in    = 6'd12;
      end else if (k == 3) begin
        i_start = 1'b0;
        i_in    = 6'd59;
      end
      cycle("ign.run");
      if (o_done) dones++;
    end
    check("ign.done_count", dones, 1);
    check("ign.ones_q", o_ones_q, 7);
    check("ign.tens_q", o_tens_q, 4);

    // Reset at edge N+3 aborts the conversion without a done pulse.
    i_in    = 6'd25;
    i_start = 1'b1;
    cycle("abort.cap");
    i_start = 1'b0;
    for (int k = 1; k <= 3; k++) cycle("abort.run");
    async_reset("abort.rst");
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      cycle("abort.after");
      if (o_done) dones++;
    end
    check("abort.no_done", dones, 0);
    check("abort.tens_q0", o_tens_q, 0);

    // Next start with 63 -> 3/6.
    i_in    = 6'd63;
    i_start = 1'b1;
    cycle("s63.cap");
    i_start = 1'b0;
    for (int k = 1; k <= 6; k++) cycle("s63.run");
    check("s63.done", o_done, 1);
    check("s63.ones_q", o_ones_q, 3);
    check("s63.tens_q", o_tens_q, 6);
    check("s63.tens_b3", o_tens_q[3], 0);

    // Start held high: back-to-back every 7 cycles, 9 -> 9/0, 50 -> 0/5.
    i_in    = 6'd9;
    i_start = 1'b1;
    cycle("b2b.cap");
    i_in = 6'd50;
    for (int k = 1; k <= 13; k++) begin
      cycle("b2b.run");
      if (k == 6) begin
        check("b2b.done1", o_done, 1);
        check("b2b.ones1", o_ones_q, 9);
        check("b2b.tens1", o_tens_q, 0);
      end else if (k == 13) begin
        check("b2b.done2", o_done, 1);
        check("b2b.ones2", o_ones_q, 0);
        check("b2b.tens2", o_tens_q, 5);
      end else begin
        check("b2b.done_off", o_done, 0);
      end
    end
    i_start = 1'b0;
    for (int k = 0; k < 8; k++) cycle("b2b.drain");

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      i_in    = 6'($urandom_range(0, 63));
      i_start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd.rst");
      end else begin
        cycle("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bcd

// File: doc/bcd.md
BCD -- requirements
Module: bcd

Interface
REQ-001 Parameters: none; input width fixed at 6 bits, digit width fixed at 4 bits.
REQ-002 i_clk  input  1  system clock; all registers sample on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_in  input  6  unsigned binary value 0..63.
REQ-005 o_ones  output  4  combinational ones digit of i_in.
REQ-006 o_tens  output  4  combinational tens digit of i_in.
REQ-007 i_start  input  1  request a registered conversion of i_in; sampled on the rising edge.
REQ-008 o_busy  output  1  registered conversion in progress.
REQ-009 o_done  output  1  one-cycle pulse marking a completed registered conversion.
REQ-010 o_ones_q  output  4  registered ones digit of the last completed conversion.
REQ-011 o_tens_q  output  4  registered tens digit of the last completed conversion.

Function
REQ-012 o_ones SHALL equal i_in mod 10 and o_tens SHALL equal i_in div 10, purely combinationally, for all 64 inputs.
REQ-013 Combinational outputs SHALL settle within the same time step as an i_in change, with no dependence on i_clk, i_rst or FSM state, including during reset.
REQ-014 o_tens SHALL be in 0..6; bit 3 of o_tens and o_tens_q SHALL always be 0.
REQ-015 Registered path SHALL be an FSM with states IDLE and CONVERT.
REQ-016 In IDLE, i_start=1 at edge N SHALL capture i_in into an internal 6-bit shift register, clear the digit registers, and enter CONVERT.
REQ-017 CONVERT SHALL execute one shift-add-3 (double-dabble) step per edge, N+1 through N+6: add 3 to any digit >=5, then shift left one bit.
REQ-018 At edge N+6, the FSM SHALL load o_ones_q/o_tens_q, assert o_done for exactly one cycle, and return to IDLE.
REQ-019 o_busy SHALL be 1 from after edge N until after edge N+6; o_busy and o_done SHALL never both be 1.
REQ-020 i_start while o_busy=1 SHALL be ignored, with no effect on the running conversion.
REQ-021 i_start in the cycle o_done=1 SHALL be accepted, giving back-to-back conversions every 7 cycles.
REQ-022 i_in changes after the capture edge SHALL NOT affect the registered result.
REQ-023 o_ones_q/o_tens_q SHALL hold their value until the next completed conversion.
REQ-024 The registered result SHALL match the combinational result for the captured value.

Reset
REQ-025 Asserting i_rst SHALL immediately force: FSM=IDLE, o_busy=0, o_done=0, o_ones_q=0, o_tens_q=0, internal shift and digit registers=0.
REQ-026 Reset asserted mid-conversion SHALL abort it with no o_done pulse.
REQ-027 The first i_start is honoured on the first rising edge after i_rst deasserts.

Structure
REQ-028 Shared package bcd_pkg SHALL hold the FSM state typedef, the IN_W=6 and DIGIT_W=4 constants, and the step count 6.
REQ-029 One sub-module, bcd_add3 (4-bit in/out: add 3 if >=5), SHALL be the digit-correction cell used by the sequential datapath; the combinational path may reuse it or use divide/modulo logic.

Verification
REQ-030 Sweep i_in 0..63 with #1 settle -> o_ones=i mod 10, o_tens=i div 10 for every value (e.g., 63 -> 3/6, 0 -> 0/0, 10 -> 0/1).
REQ-031 i_in=47, i_start pulse at edge N -> o_busy high for 6 cycles; at edge N+6, o_done=1 for one cycle, o_ones_q=7, o_tens_q=4.
REQ-032 i_start again while busy with i_in=12 -> ignored; result remains 7/4 and o_done pulses once.
REQ-033 Change i_in to 59 after the capture edge -> result remains that of the captured value.
REQ-034 Assert i_rst at edge N+3 of a conversion -> o_busy=0, outputs 0, no o_done; next start with 63 -> 3/6 after 6 cycles.
REQ-035 Start held high continuously with i_in=9 then 50 -> conversions complete every 7 cycles with results 9/0 then 0/5.
